mips_mc: RTL and testbench

//  Parametrised multi-cycle successor of the single-cycle MIPS core. Executes

---
 rtl/mips_mc.sv | 198 +++++++++++++++++++
 tb/tb_mips_mc.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc.sv
// Multi-cycle MIPS core (addu/subu/ori/lui/lw/sw/beq/j) with external IM and req/ack data memory.
// Optional performance counters are enabled with `define MIPS_MC_PERF_CNT_EN.
`timescale 1ns/1ps
module mips_mc #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IM_AW    = 10,
    parameter int          DM_AW    = 10
) (
    input  logic             clk,
    input  logic             rst,
    output logic [IM_AW-1:0] imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [DM_AW-1:0] dmem_addr,
    output logic [31:0]      dmem_wdata,
    input  logic [31:0]      dmem_rdata,
    input  logic             dmem_ack,
    output logic [31:0]      pc,
    output logic             retire,
    output logic             illegal,
    input  logic [4:0]       dbg_addr,
    output logic [31:0]      dbg_data
`ifdef MIPS_MC_PERF_CNT_EN
    ,
    output logic [31:0]      cycle_cnt,
    output logic [31:0]      instret_cnt
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t state, state_next;

    logic [31:0] ir, reg_a, reg_b, alu_out, mdr;
    logic [31:0] gpr [0:31];

    function automatic logic signed [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    logic [5:0]         op, funct;
    logic [4:0]         rs, rt, rd, dest;
    logic [15:0]        imm;
    logic signed [31:0] imm_sext;
    logic [31:0]        br_off, pc_plus4, exec_pc, alu_res, rs_val, rt_val;
    logic               is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j;
    logic               legal, pc_borrow;

    assign op       = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign imm      = ir[15:0];
    assign imm_sext = sext16(imm);
    assign br_off   = {{14{imm[15]}}, imm, 2'b00};

    assign is_addu = (op == OP_RTYPE) && (funct == FN_ADDU);
    assign is_subu = (op == OP_RTYPE) && (funct == FN_SUBU);
    assign is_ori  = (op == OP_ORI);
    assign is_lui  = (op == OP_LUI);
    assign is_lw   = (op == OP_LW);
    assign is_sw   = (op == OP_SW);
    assign is_beq  = (op == OP_BEQ);
    assign is_j    = (op == OP_J);
    assign legal   = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw | is_beq | is_j;
    assign dest    = (is_addu | is_subu) ? rd : rt;

    assign rs_val   = (rs == 5'd0) ? 32'd0 : gpr[rs];
    assign rt_val   = (rt == 5'd0) ? 32'd0 : gpr[rt];
    assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : gpr[dbg_addr];

    assign pc_plus4 = pc + 32'd4;

    // Word index of (pc - RESET_PC), including the borrow out of the byte-offset bits.
    assign pc_borrow = (pc[1:0] < RESET_PC[1:0]);
    assign imem_addr = pc[IM_AW+1:2] - RESET_PC[IM_AW+1:2] - IM_AW'(pc_borrow);

    assign dmem_addr  = alu_out[DM_AW+1:2];
    assign dmem_wdata = reg_b;
    assign dmem_we    = (state == S_MEM) && is_sw;

    always_comb begin
        alu_res = 32'd0;
        if (is_addu)            alu_res = reg_a + reg_b;
        else if (is_subu)       alu_res = reg_a - reg_b;
        else if (is_ori)        alu_res = reg_a | {16'h0000, imm};
        else if (is_lui)        alu_res = {imm, 16'h0000};
        else if (is_lw | is_sw) alu_res = reg_a + imm_sext;
    end

    always_comb begin
        exec_pc = pc_plus4;
        if (is_beq && (reg_a == reg_b)) exec_pc = pc_plus4 + br_off;
        else if (is_j)                  exec_pc = {pc_plus4[31:28], ir[25:0], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        retire     = 1'b0;
        illegal    = 1'b0;
        dmem_req   = 1'b0;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                if (is_lw | is_sw) begin
                    state_next = S_MEM;
                end else if (is_addu | is_subu | is_ori | is_lui) begin
                    state_next = S_WB;
                end else begin
                    retire     = 1'b1;
                    illegal    = ~legal;
                    state_next = S_FETCH;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    retire     = is_sw;
                    state_next = is_sw ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Architectural state: pc and register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            for (int i = 0; i < 32; i++) gpr[i] <= 32'd0;
        end else begin
            case (state)
                S_EXEC: if (!(is_lw | is_sw | is_addu | is_subu | is_ori | is_lui)) pc <= exec_pc;
                S_MEM:  if (dmem_ack && is_sw) pc <= pc_plus4;
                S_WB: begin
                    pc <= pc_plus4;
                    if (dest != 5'd0) gpr[dest] <= is_lw ? mdr : alu_out;
                end
                default: ;
            endcase
        end
    end

    // Internal datapath latches; contents are don't-care until written.
    always_ff @(posedge clk) begin
        case (state)
            S_FETCH:  ir <= imem_rdata;
            S_DECODE: begin
                reg_a <= rs_val;
                reg_b <= rt_val;
            end
            S_EXEC:   alu_out <= alu_res;
            S_MEM:    if (dmem_ack && is_lw) mdr <= dmem_rdata;
            default: ;
        endcase
    end

`ifdef MIPS_MC_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= 32'd0;
            instret_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (retire) instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_mc.sv
// Directed bench for mips_mc: tiny programs in a bench-owned IM, data memory with programmable ack delay.
`timescale 1ns/1ps
module tb_mips_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        dmem_req, dmem_we;
    logic [9:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = 32'd0;
    logic        dmem_ack = 1'b0;
    logic [31:0] pc;
    logic        retire, illegal;
    logic [4:0]  dbg_addr = 5'd0;
    logic [31:0] dbg_data;
`ifdef MIPS_MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    mips_mc dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .pc         (pc),
        .retire     (retire),
        .illegal    (illegal),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
`ifdef MIPS_MC_PERF_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] im [0:1023];
    logic [31:0] dm [0:1023];
    assign imem_rdata = im[imem_addr];

    int          total = 0;
    int          passed = 0;
    int          cyc = 0;
    int          last_ret_cyc = 0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    bit          ack_force = 1'b0;
    int          req_cycles;
    logic [31:0] req_addr, req_wdata;
    logic        req_we;
    bit          req_stable;
    logic [31:0] v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Advance to the next falling edge and drive the memory response for the coming rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (ack_force) begin
            dmem_ack = 1'b1;
        end else if (dmem_req) begin
            if (wait_cnt >= ack_delay) begin
                dmem_ack = 1'b1;
                wait_cnt = 0;
                if (dmem_we) dm[dmem_addr] = dmem_wdata;
                else         dmem_rdata = dm[dmem_addr];
            end else begin
                dmem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            dmem_ack = 1'b0;
            wait_cnt = 0;
        end
        #1;
    endtask

    task automatic rd_gpr(input logic [4:0] a, output logic [31:0] d);
        dbg_addr = a;
        #0.1;
        d = dbg_data;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        dmem_ack = 1'b0;
        wait_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 1;
        #1;
    endtask

    // Runs from the instruction's FETCH cycle to its retire, then steps into the next FETCH.
    task automatic run_instr(input string tag, input int exp_n, input logic exp_ill);
        int n;
        n = 1;
        req_cycles = 0;
        req_stable = 1'b1;
        while (1) begin
            if (dmem_req) begin
                if (req_cycles == 0) begin
                    req_addr  = 32'(dmem_addr);
                    req_we    = dmem_we;
                    req_wdata = dmem_wdata;
                end else if (32'(dmem_addr) != req_addr || dmem_we != req_we || dmem_wdata != req_wdata) begin
                    req_stable = 1'b0;
                end
                req_cycles++;
            end
            if (retire || n >= 60) break;
            tick();
            n++;
        end
        last_ret_cyc = cyc;
        check({tag, "_lat"}, 32'(n), 32'(exp_n));
        check({tag, "_ill"}, 32'(illegal), 32'(exp_ill));
        tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            im[i] = 32'd0;
            dm[i] = 32'd0;
        end
        im[0] = 32'h3401_1234;  // ori  $1,$0,0x1234
        im[1] = 32'h3C02_ABCD;  // lui  $2,0xABCD
        im[2] = 32'h0022_1821;  // addu $3,$1,$2
        im[3] = 32'h3401_0001;  // ori  $1,$0,1
        im[4] = 32'h0001_1823;  // subu $3,$0,$1
        im[5] = 32'h3400_FFFF;  // ori  $0,$0,0xFFFF
        im[6] = 32'hAC03_0008;  // sw   $3,8($0)
        im[7] = 32'h8C04_0008;  // lw   $4,8($0)

        // Reset state
        do_reset();
        check("rst_pc", pc, 32'h0000_3000);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_we", 32'(dmem_we), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        for (int i = 0; i < 32; i++) begin
            rd_gpr(5'(i), v);
            check($sformatf("rst_gpr%0d", i), v, 32'd0);
        end
`ifdef MIPS_MC_PERF_CNT_EN
        check("rst_cycle_cnt", cycle_cnt, 32'd0);
        check("rst_instret_cnt", instret_cnt, 32'd0);
`endif

        // ori / lui / addu with absolute retire cycles
        run_instr("ori1", 4, 1'b0);
        check("ori1_cyc", 32'(last_ret_cyc), 32'd4);
        run_instr("lui2", 4, 1'b0);
        check("lui2_cyc", 32'(last_ret_cyc), 32'd8);
        run_instr("addu3", 4, 1'b0);
        check("addu3_cyc", 32'(last_ret_cyc), 32'd12);
        check("t2_pc", pc, 32'h0000_300C);
        check("t2_imem_addr", 32'(imem_addr), 32'd3);
        rd_gpr(5'd1, v); check("t2_r1", v, 32'h0000_1234);
        rd_gpr(5'd2, v); check("t2_r2", v, 32'hABCD_0000);
        rd_gpr(5'd3, v); check("t2_r3", v, 32'hABCD_1234);

        // subu wrap and $0 write discard
        run_instr("ori_1", 4, 1'b0);
        run_instr("subu", 4, 1'b0);
        rd_gpr(5'd3, v); check("t3_r3", v, 32'hFFFF_FFFF);
        run_instr("ori_r0", 4, 1'b0);
        rd_gpr(5'd0, v); check("t3_r0", v, 32'd0);
        check("t3_pc", pc, 32'h0000_3018);

        // sw with 3 wait cycles, then lw
        ack_delay = 3;
        run_instr("sw", 7, 1'b0);
        check("sw_req_cycles", 32'(req_cycles), 32'd4);
        check("sw_addr", req_addr, 32'd2);
        check("sw_we", 32'(req_we), 32'd1);
        check("sw_wdata", req_wdata, 32'hFFFF_FFFF);
        check("sw_stable", 32'(req_stable), 32'd1);
        check("sw_dm2", dm[2], 32'hFFFF_FFFF);
        ack_delay = 0;
        run_instr("lw", 5, 1'b0);
        check("lw_req_cycles", 32'(req_cycles), 32'd1);
        check("lw_we", 32'(req_we), 32'd0);
        rd_gpr(5'd4, v); check("lw_r4", v, 32'hFFFF_FFFF);
        check("t4_pc", pc, 32'h0000_3020);

        // Branches, jump, illegal opcode
        for (int i = 0; i < 8; i++) im[i] = 32'd0;
        im[0] = 32'h1021_0002;  // beq $1,$1,+2
        im[3] = 32'h3401_0005;  // ori $1,$0,5
        im[4] = 32'h1020_0002;  // beq $1,$0,+2
        im[5] = 32'h0800_0C03;  // j   0x0C03
        do_reset();
        rd_gpr(5'd3, v); check("t5_rst_r3", v, 32'd0);
        run_instr("beq_t", 3, 1'b0);
        check("beq_t_pc", pc, 32'h0000_300C);
        run_instr("ori5", 4, 1'b0);
        run_instr("beq_nt", 3, 1'b0);
        check("beq_nt_pc", pc, 32'h0000_3014);
        im[3] = 32'hFC00_0000;  // opcode 0x3F
        run_instr("j", 3, 1'b0);
        check("j_pc", pc, 32'h0000_300C);
        run_instr("illegal", 3, 1'b1);
        check("illegal_pc", pc, 32'h0000_3010);
        rd_gpr(5'd1, v); check("illegal_r1", v, 32'h0000_0005);

        // Reset during a MEM wait, late ack ignored
        for (int i = 0; i < 8; i++) im[i] = 32'd0;
        for (int i = 0; i < 8; i++) dm[i] = 32'd0;
        im[0] = 32'h3405_0077;  // ori $5,$0,0x77
        im[1] = 32'hAC05_0000;  // sw  $5,0($0)
        do_reset();
        ack_delay = 100;
        run_instr("t6_ori", 4, 1'b0);
        for (int i = 0; i < 10 && !dmem_req; i++) tick();
        check("t6_req_seen", 32'(dmem_req), 32'd1);
        tick();
        tick();
        rst = 1'b1;
        ack_force = 1'b1;
        tick();
        check("t6_req_after_rst", 32'(dmem_req), 32'd0);
        check("t6_pc_after_rst", pc, 32'h0000_3000);
        check("t6_retire_after_rst", 32'(retire), 32'd0);
        rd_gpr(5'd5, v); check("t6_r5_cleared", v, 32'd0);
`ifdef MIPS_MC_PERF_CNT_EN
        check("t6_cycle_cnt", cycle_cnt, 32'd0);
        check("t6_instret_cnt", instret_cnt, 32'd0);
`endif
        rst = 1'b0;
        cyc = 1;
        run_instr("t6_ori_late_ack", 4, 1'b0);
        check("t6_pc_ori", pc, 32'h0000_3004);
        ack_force = 1'b0;
        ack_delay = 0;
        run_instr("t6_sw", 4, 1'b0);
        check("t6_dm0", dm[0], 32'h0000_0077);
        check("t6_pc_sw", pc, 32'h0000_3008);
`ifdef MIPS_MC_PERF_CNT_EN
        check("t6_cycle_cnt_end", cycle_cnt, 32'd8);
        check("t6_instret_cnt_end", instret_cnt, 32'd2);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
